// File: rtl/mrv_seq_ctrl.sv
// Multicycle sequencer for the miniRV core: fetch/decode/execute/memory/writeback
// control with memory handshakes, writeback select lines and sticky trap reporting.
// Every output is a register loaded from the next state, so outputs line up with the
// state they belong to and never glitch.
module mrv_seq_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] inst,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_wmask,
  input  logic        dmem_ack,
  input  logic [1:0]  addr10,
  output logic        ir_we,
  output logic        alusrc_imm,
  output logic        isload,
  output logic        islbu,
  output logic        islui,
  output logic        jumpornot,
  output logic        rf_we,
  output logic        pc_we,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    StBoot,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StTrap
  } state_e;

  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CntMax  = '1;
  localparam logic [CW-1:0] CntOne  = CW'(1);

  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpI    = 7'b0010011;
  localparam logic [6:0] OpLui  = 7'b0110111;
  localparam logic [6:0] OpLd   = 7'b0000011;
  localparam logic [6:0] OpSt   = 7'b0100011;
  localparam logic [6:0] OpJalr = 7'b1100111;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Only the opcode, funct3 and funct7 fields matter for sequencing.
  logic [6:0]    op_q, op_d;
  logic [2:0]    f3_q, f3_d;
  logic [6:0]    f7_q, f7_d;

  // Instruction class, captured when DECODE completes.
  logic          ld_q, ld_d;
  logic          st_q, st_d;
  logic          byte_q, byte_d;

  logic          imem_req_q, imem_req_d;
  logic          dmem_req_q, dmem_req_d;
  logic          dmem_we_q, dmem_we_d;
  logic [3:0]    wmask_q, wmask_d;
  logic          ir_we_q, ir_we_d;
  logic          alusrc_q, alusrc_d;
  logic          isload_q, isload_d;
  logic          islbu_q, islbu_d;
  logic          islui_q, islui_d;
  logic          jump_q, jump_d;
  logic          rf_we_q, rf_we_d;
  logic          pc_we_q, pc_we_d;
  logic          trap_q, trap_d;
  logic [1:0]    cause_q, cause_d;
  logic [31:0]   instret_q, instret_d;

  logic          dec_add, dec_addi, dec_lui, dec_lw, dec_lbu, dec_sw, dec_sb, dec_jalr;
  logic          dec_legal;
  logic          unused_inst;

  assign unused_inst = ^{inst[24:15], inst[11:7]};

  // Decode the captured instruction fields.
  always_comb begin
    dec_add   = (op_q == OpR) && (f3_q == 3'b000) && (f7_q == 7'b0000000);
    dec_addi  = (op_q == OpI) && (f3_q == 3'b000);
    dec_lui   = (op_q == OpLui);
    dec_lw    = (op_q == OpLd) && (f3_q == 3'b010);
    dec_lbu   = (op_q == OpLd) && (f3_q == 3'b100);
    dec_sw    = (op_q == OpSt) && (f3_q == 3'b010);
    dec_sb    = (op_q == OpSt) && (f3_q == 3'b000);
    dec_jalr  = (op_q == OpJalr) && (f3_q == 3'b000);
    dec_legal = dec_add | dec_addi | dec_lui | dec_lw | dec_lbu | dec_sw | dec_sb | dec_jalr;
  end

  // Next-state, wait counter and registered-output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    f3_d      = f3_q;
    f7_d      = f7_q;
    ld_d      = ld_q;
    st_d      = st_q;
    byte_d    = byte_q;
    cause_d   = cause_q;
    instret_d = instret_q;

    unique case (state_q)
      StBoot: state_d = StFetch;
      StFetch: begin
        if (imem_ack) begin
          op_d    = inst[6:0];
          f3_d    = inst[14:12];
          f7_d    = inst[31:25];
          state_d = StDecode;
        end else if (cnt_q == CntLast) begin
          state_d = StTrap;
          cause_d = 2'b10;
        end
      end
      StDecode: begin
        if (dec_legal) begin
          ld_d    = dec_lw | dec_lbu;
          st_d    = dec_sw | dec_sb;
          byte_d  = dec_lbu | dec_sb;
          state_d = StExec;
        end else begin
          state_d = StTrap;
          cause_d = 2'b01;
        end
      end
      StExec: state_d = (ld_q || st_q) ? StMem : StWb;
      StMem: begin
        if (dmem_ack) begin
          state_d = StWb;
        end else if (cnt_q == CntLast) begin
          state_d = StTrap;
          cause_d = 2'b11;
        end
      end
      StWb: begin
        state_d   = StFetch;
        instret_d = instret_q + 32'd1;
      end
      StTrap: state_d = StTrap;
      default: state_d = StBoot;
    endcase

    // Count unacknowledged request cycles; restart on each new request.
    if ((state_d == StFetch && state_q != StFetch) || (state_d == StMem && state_q != StMem)) begin
      cnt_d = '0;
    end else if (((state_q == StFetch && !imem_ack) || (state_q == StMem && !dmem_ack)) &&
                 (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntOne;
    end

    imem_req_d = (state_d == StFetch);
    ir_we_d    = (state_q == StFetch) && (state_d == StDecode);
    dmem_req_d = (state_d == StMem);
    dmem_we_d  = (state_d == StMem) && st_q;
    rf_we_d    = (state_d == StWb) && !st_q;
    pc_we_d    = (state_d == StWb);
    trap_d     = (state_d == StTrap);

    // Byte mask is fixed from the EXEC address and held for the whole request.
    wmask_d = 4'b0000;
    if (state_q == StExec && state_d == StMem) begin
      if (st_q) wmask_d = byte_q ? (4'b0001 << addr10) : 4'b1111;
    end else if (state_d == StMem) begin
      wmask_d = wmask_q;
    end

    // Writeback selects live from DECODE exit until WB exit.
    alusrc_d = alusrc_q;
    isload_d = isload_q;
    islbu_d  = islbu_q;
    islui_d  = islui_q;
    jump_d   = jump_q;
    if (state_q == StDecode && state_d == StExec) begin
      alusrc_d = dec_addi | dec_lw | dec_lbu | dec_sw | dec_sb | dec_jalr;
      isload_d = dec_lw | dec_lbu;
      islbu_d  = dec_lbu;
      islui_d  = dec_lui;
      jump_d   = dec_jalr;
    end else if (state_q == StWb || state_d == StTrap) begin
      alusrc_d = 1'b0;
      isload_d = 1'b0;
      islbu_d  = 1'b0;
      islui_d  = 1'b0;
      jump_d   = 1'b0;
    end
  end

  // State and output registers; reset forces BOOT with all outputs low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StBoot;
      cnt_q      <= '0;
      op_q       <= '0;
      f3_q       <= '0;
      f7_q       <= '0;
      ld_q       <= 1'b0;
      st_q       <= 1'b0;
      byte_q     <= 1'b0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      wmask_q    <= 4'b0000;
      ir_we_q    <= 1'b0;
      alusrc_q   <= 1'b0;
      isload_q   <= 1'b0;
      islbu_q    <= 1'b0;
      islui_q    <= 1'b0;
      jump_q     <= 1'b0;
      rf_we_q    <= 1'b0;
      pc_we_q    <= 1'b0;
      trap_q     <= 1'b0;
      cause_q    <= 2'b00;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      f3_q       <= f3_d;
      f7_q       <= f7_d;
      ld_q       <= ld_d;
      st_q       <= st_d;
      byte_q     <= byte_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      wmask_q    <= wmask_d;
      ir_we_q    <= ir_we_d;
      alusrc_q   <= alusrc_d;
      isload_q   <= isload_d;
      islbu_q    <= islbu_d;
      islui_q    <= islui_d;
      jump_q     <= jump_d;
      rf_we_q    <= rf_we_d;
      pc_we_q    <= pc_we_d;
      trap_q     <= trap_d;
      cause_q    <= cause_d;
      instret_q  <= instret_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_wmask = wmask_q;
  assign ir_we      = ir_we_q;
  assign alusrc_imm = alusrc_q;
  assign isload     = isload_q;
  assign islbu      = islbu_q;
  assign islui      = islui_q;
  assign jumpornot  = jump_q;
  assign rf_we      = rf_we_q;
  assign pc_we      = pc_we_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_mrv_seq_ctrl.sv
// Directed bench for mrv_seq_ctrl with hand-computed expectations (TIMEOUT=4).
module tb_mrv_seq_ctrl;

  localparam logic [31:0] Addi = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] Lbu  = 32'h0030_4103;  // lbu  x2,3(x0)
  localparam logic [31:0] Sb   = 32'h0000_0023;  // sb   x0,0(x0)
  localparam logic [31:0] Sw   = 32'h0000_2023;  // sw   x0,0(x0)
  localparam logic [31:0] Lw   = 32'h0000_2083;  // lw   x1,0(x0)
  localparam logic [31:0] Lui  = 32'h0000_10b7;  // lui  x1,1
  localparam logic [31:0] Jalr = 32'h0000_8067;  // jalr x0,0(x1)
  localparam logic [31:0] Add  = 32'h0020_81b3;  // add  x3,x1,x2
  localparam logic [31:0] Bad  = 32'hffff_ffff;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack;
  logic [31:0] inst;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [3:0]  dmem_wmask;
  logic [1:0]  addr10;
  logic        ir_we, alusrc_imm, isload, islbu, islui, jumpornot;
  logic        rf_we, pc_we, trap;
  logic [1:0]  trap_cause;
  logic [31:0] instret;
  logic [17:0] outs;

  int n_vec = 0;
  int n_err = 0;
  int n;

  assign outs = {imem_req, dmem_req, dmem_we, dmem_wmask, ir_we, alusrc_imm, isload, islbu,
                 islui, jumpornot, rf_we, pc_we, trap, trap_cause};

  always #5 clk = ~clk;

  mrv_seq_ctrl #(
    .TIMEOUT(4),
    .CW     (3)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .inst      (inst),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_wmask(dmem_wmask),
    .dmem_ack  (dmem_ack),
    .addr10    (addr10),
    .ir_we     (ir_we),
    .alusrc_imm(alusrc_imm),
    .isload    (isload),
    .islbu     (islbu),
    .islui     (islui),
    .jumpornot (jumpornot),
    .rf_we     (rf_we),
    .pc_we     (pc_we),
    .trap      (trap),
    .trap_cause(trap_cause),
    .instret   (instret)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled mid-cycle.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the DUT in BOOT just after reset release.
  task automatic apply_reset();
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    inst     = 32'h0;
    addr10   = 2'b00;
    rst_n    = 1'b0;
    @(negedge clk);
    check("rst_outs", 32'(outs), 32'h0);
    check("rst_instret", instret, 32'h0);
    rst_n = 1'b1;
  endtask

  // Called in a FETCH cycle; returns in DECODE.
  task automatic fetch(input logic [31:0] w);
    inst     = w;
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
  endtask

  // Count consecutive cycles with dmem_req high, acking on cycle ack_at (0 = never).
  task automatic count_dmem(input int ack_at, output int cnt);
    cnt = 0;
    while (dmem_req && cnt < 20) begin
      cnt++;
      if (cnt == ack_at) dmem_ack = 1'b1;
      step();
    end
    dmem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    inst     = 32'h0;
    addr10   = 2'b00;
    #3;

    // addi with imem_ack tied high from release
    apply_reset();
    imem_ack = 1'b1;
    inst     = Addi;
    check("boot_req", 32'(imem_req), 32'h0);
    step();
    check("addi_f_req", 32'(imem_req), 32'h1);
    check("addi_f_irwe", 32'(ir_we), 32'h0);
    step();
    imem_ack = 1'b0;
    check("addi_d_irwe", 32'(ir_we), 32'h1);
    check("addi_d_req", 32'(imem_req), 32'h0);
    step();
    check("addi_e_alusrc", 32'(alusrc_imm), 32'h1);
    check("addi_e_rfwe", 32'(rf_we), 32'h0);
    step();
    check("addi_wb_rfwe", 32'(rf_we), 32'h1);
    check("addi_wb_pcwe", 32'(pc_we), 32'h1);
    check("addi_wb_alusrc", 32'(alusrc_imm), 32'h1);
    check("addi_wb_instret", instret, 32'd0);
    step();
    check("addi_instret", instret, 32'd1);
    check("addi_sel_clr", 32'(alusrc_imm), 32'h0);
    check("addi_refetch", 32'(imem_req), 32'h1);

    // lbu, ack after three wait cycles
    fetch(Lbu);
    step();
    addr10 = 2'b11;
    check("lbu_e_sel", 32'({isload, islbu}), 32'h3);
    check("lbu_e_dreq", 32'(dmem_req), 32'h0);
    step();
    check("lbu_m_we", 32'(dmem_we), 32'h0);
    check("lbu_m_mask", 32'(dmem_wmask), 32'h0);
    count_dmem(4, n);
    check("lbu_req_cycles", n, 4);
    check("lbu_wb_sel", 32'({isload, islbu}), 32'h3);
    check("lbu_wb_strobes", 32'({rf_we, pc_we}), 32'h3);
    step();
    check("lbu_instret", instret, 32'd2);
    check("lbu_sel_clr", 32'({isload, islbu}), 32'h0);

    // sb to byte lane 2
    fetch(Sb);
    step();
    addr10 = 2'b10;
    step();
    check("sb_m_req_we", 32'({dmem_req, dmem_we}), 32'h3);
    check("sb_m_mask", 32'(dmem_wmask), 32'h4);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    check("sb_wb_pcwe", 32'(pc_we), 32'h1);
    check("sb_wb_rfwe", 32'(rf_we), 32'h0);
    check("sb_wb_dreq", 32'(dmem_req), 32'h0);
    step();

    // lui and jalr select lines
    fetch(Lui);
    step();
    check("lui_e_sel", 32'({islui, alusrc_imm, jumpornot}), 32'h4);
    step();
    check("lui_wb_rfwe", 32'(rf_we), 32'h1);
    step();
    fetch(Jalr);
    step();
    check("jalr_e_sel", 32'({islui, alusrc_imm, jumpornot}), 32'h3);
    step();
    check("jalr_wb_strobes", 32'({rf_we, pc_we, jumpornot}), 32'h7);
    step();
    check("jalr_instret", instret, 32'd5);

    // illegal opcode traps and stays trapped with acks present
    fetch(Bad);
    step();
    check("ill_trap", 32'({trap, trap_cause}), 32'h5);
    check("ill_strobes", 32'({rf_we, pc_we, imem_req}), 32'h0);
    imem_ack = 1'b1;
    repeat (5) step();
    imem_ack = 1'b0;
    check("ill_hold_req", 32'(imem_req), 32'h0);
    check("ill_hold_trap", 32'({trap, trap_cause}), 32'h5);
    check("ill_instret", instret, 32'd5);

    // fetch timeout
    apply_reset();
    step();
    n = 0;
    while (imem_req && n < 20) begin
      n++;
      step();
    end
    check("ito_req_cycles", n, 4);
    check("ito_trap", 32'({trap, trap_cause}), 32'h6);

    // fetch ack on the last allowed cycle wins
    apply_reset();
    step();
    n = 0;
    while (imem_req && n < 20) begin
      n++;
      if (n == 4) begin
        imem_ack = 1'b1;
        inst     = Add;
      end
      step();
    end
    imem_ack = 1'b0;
    check("ilate_req_cycles", n, 4);
    check("ilate_decode", 32'({ir_we, trap}), 32'h2);
    step();
    check("add_e_sel", 32'({alusrc_imm, trap}), 32'h0);
    step();
    check("add_wb_rfwe", 32'(rf_we), 32'h1);
    step();

    // data timeout on lw: no writeback
    fetch(Lw);
    step();
    step();
    count_dmem(0, n);
    check("dto_req_cycles", n, 4);
    check("dto_trap", 32'({trap, trap_cause}), 32'h7);
    check("dto_strobes", 32'({rf_we, pc_we}), 32'h0);
    check("dto_instret", instret, 32'd1);

    // reset during sw MEM
    apply_reset();
    step();
    fetch(Sw);
    step();
    addr10 = 2'b01;
    step();
    check("sw_m_mask", 32'(dmem_wmask), 32'hf);
    check("sw_m_we", 32'(dmem_we), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("sw_rst_async", 32'(outs), 32'h0);
    dmem_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    check("sw_rst_boot", 32'(outs), 32'h0);
    step();
    check("sw_rel_fetch", 32'({imem_req, dmem_req, pc_we}), 32'h4);
    step();
    check("sw_rel_nopc", 32'({dmem_req, pc_we, rf_we}), 32'h0);
    check("sw_rel_instret", instret, 32'd0);
    dmem_ack = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
